// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arbiter_pkg: shared types for the fetch/data memory arbiter |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package mem_port_arbiter_pkg;

    localparam int unsigned C_STARVE_LIMIT = 4;

    typedef logic [31:0] Addr;
    typedef logic [31:0] Data;
    typedef logic        Bool;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_I = 3'd1,
        ST_ISSUE_D = 3'd2,
        ST_WAIT_I  = 3'd3,
        ST_WAIT_D  = 3'd4,
        ST_DROP    = 3'd5
    } MemArbState;

endpackage
`default_nettype wire

// File: rtl/mem_arb_fairness.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arb_fairness: data-first winner select with a fetch starvation   |
// | guard. Revision: 1.0                                                |
// +--------------------------------------------------------------------+
module mem_arb_fairness
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = C_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant,
    output logic winner_is_fetch,
    output logic winner_valid
);

    localparam int unsigned C_CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(STARVE_LIMIT);

    logic [C_CNT_W-1:0] streak_q;
    logic [C_CNT_W-1:0] streak_d;
    Bool                w_starved;

    assign w_starved       = (streak_q == C_LIMIT);
    assign winner_valid    = if_req | dm_req;
    assign winner_is_fetch = if_req & (~dm_req | w_starved);

    // Only data grants taken while fetch is waiting count toward starvation.
    always_comb begin
        streak_d = streak_q;
        if (grant) begin
            if (winner_is_fetch || !if_req) begin
                streak_d = '0;
            end else if (!w_starved) begin
                streak_d = streak_q + C_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arbiter: shares one memory port between fetch and data,    |
// | one transaction outstanding, fetch discard support. Revision: 1.0   |
// +--------------------------------------------------------------------+
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = C_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_discard,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    MemArbState        state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    Bool w_grant;
    Bool w_win_fetch;
    Bool w_win_valid;
    Bool w_to_idle;
    Bool w_waiting;

    assign w_grant   = (state_q == ST_IDLE) & w_win_valid;
    assign w_waiting = (state_q == ST_WAIT_I) | (state_q == ST_WAIT_D) | (state_q == ST_DROP);
    assign w_to_idle = ((state_q == ST_ISSUE_I) & if_discard & ~mem_gnt)
                     | (w_waiting & mem_rvalid);

    mem_arb_fairness #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fairness (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_req          (if_req),
        .dm_req          (dm_req),
        .grant           (w_grant),
        .winner_is_fetch (w_win_fetch),
        .winner_valid    (w_win_valid)
    );

    // Leaving for IDLE always clears the memory-side registers so IDLE reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (w_to_idle) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        mem_req_q <= 1'b1;
                        if (w_win_fetch) begin
                            state_q     <= ST_ISSUE_I;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end else begin
                            state_q     <= ST_ISSUE_D;
                            mem_we_q    <= dm_we;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                        end
                    end
                end
                ST_ISSUE_I: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= if_discard ? ST_DROP : ST_WAIT_I;
                    end
                end
                ST_ISSUE_D: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_WAIT_D;
                    end
                end
                ST_WAIT_I: begin
                    if (if_discard) begin
                        state_q <= ST_DROP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign if_valid = (state_q == ST_WAIT_I) & mem_rvalid & ~if_discard;
    assign dm_ack   = (state_q == ST_WAIT_D) & mem_rvalid;
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_rdata = (dm_ack & ~mem_we_q) ? mem_rdata : '0;

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed scenarios plus randomized traffic      |
// | against a transaction-level model. Revision: 1.0                    |
// +--------------------------------------------------------------------+
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_discard, if_valid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ack, dm_stall;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk (clk), .rst_n (rst_n),
        .if_req (if_req), .if_addr (if_addr), .if_discard (if_discard),
        .if_valid (if_valid), .if_rdata (if_rdata), .if_stall (if_stall),
        .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
        .dm_ack (dm_ack), .dm_rdata (dm_rdata), .dm_stall (dm_stall),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_gnt (mem_gnt), .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Randomized-phase model state
    int          streak;
    int          t_lat;
    bit          t_active, t_granted, t_fetch, t_we, t_killed;
    logic [31:0] t_addr, t_wdata;
    bit          f_req, d_req, d_we;
    logic [31:0] f_addr, d_addr, d_wdata;
    bit          p_if, p_dm, p_dwe, arb_prev, idle_now, exp_fetch;
    logic [31:0] p_faddr, p_daddr, p_dwdata;
    bit          gnt_b, rv_b, rv_real, disc_b, exp_ifv, exp_ack;
    logic [31:0] rd;
    logic [31:0] memv [logic [31:0]];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; if_discard = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_dm_ack", dm_ack, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single fetch
        if_req = 1; if_addr = 32'h100; #1;
        chk("sf_stall_c0", if_stall, 1);
        chk("sf_mreq_c0", mem_req, 0);
        tick(); mem_gnt = 1; #1;
        chk("sf_mreq_c1", mem_req, 1);
        chk("sf_maddr_c1", mem_addr, 32'h100);
        chk("sf_mwe_c1", mem_we, 0);
        chk("sf_stall_c1", if_stall, 1);
        tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00A00093; #1;
        chk("sf_valid", if_valid, 1);
        chk("sf_rdata", if_rdata, 32'h00A00093);
        chk("sf_stall_c2", if_stall, 0);
        chk("sf_no_ack", dm_ack, 0);
        tick(); if_req = 0; mem_rvalid = 0; #1;
        chk("sf_valid_off", if_valid, 0);
        chk("sf_rdata_off", if_rdata, 0);
        chk("sf_idle_mreq", mem_req, 0);

        // Simultaneous requests: data first
        tick(); if_req = 1; if_addr = 32'h104; dm_req = 1; dm_we = 0; dm_addr = 32'h200; #1;
        chk("sim_mreq_c0", mem_req, 0);
        tick(); mem_gnt = 1; #1;
        chk("sim_addr_d", mem_addr, 32'h200);
        chk("sim_if_stall_c1", if_stall, 1);
        chk("sim_dm_stall_c1", dm_stall, 1);
        tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h11112222; #1;
        chk("sim_ack", dm_ack, 1);
        chk("sim_dm_rdata", dm_rdata, 32'h11112222);
        chk("sim_no_ifv", if_valid, 0);
        chk("sim_if_stall_c2", if_stall, 1);
        chk("sim_dm_stall_c2", dm_stall, 0);
        tick(); dm_req = 0; mem_rvalid = 0; #1;
        chk("sim_mreq_c3", mem_req, 0);
        chk("sim_if_stall_c3", if_stall, 1);
        tick(); mem_gnt = 1; #1;
        chk("sim_mreq_c4", mem_req, 1);
        chk("sim_addr_i", mem_addr, 32'h104);
        tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h22223333; #1;
        chk("sim_ifv", if_valid, 1);
        chk("sim_if_rdata", if_rdata, 32'h22223333);
        tick(); if_req = 0; mem_rvalid = 0;

        // Store with slow grant
        tick(); dm_req = 1; dm_we = 1; dm_addr = 32'h300; dm_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick(); mem_gnt = (i == 2); #1;
            chk("st_mreq", mem_req, 1);
            chk("st_addr", mem_addr, 32'h300);
            chk("st_we", mem_we, 1);
            chk("st_wdata", mem_wdata, 32'hDEADBEEF);
        end
        tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h55555555; #1;
        chk("st_ack", dm_ack, 1);
        chk("st_rdata_zero", dm_rdata, 0);
        tick(); dm_req = 0; dm_we = 0; mem_rvalid = 0;

        // Discard in WAIT_I, response three cycles after grant
        tick(); if_req = 1; if_addr = 32'h180;
        tick(); mem_gnt = 1; #1;
        chk("dc_mreq", mem_req, 1);
        tick(); mem_gnt = 0; if_discard = 1; #1;
        chk("dc_ifv_w", if_valid, 0);
        tick(); if_discard = 0; if_req = 0; #1;
        chk("dc_mreq_drop", mem_req, 0);
        tick(); mem_rvalid = 1; mem_rdata = 32'h00000077; #1;
        chk("dc_ifv_rv", if_valid, 0);
        chk("dc_rdata_rv", if_rdata, 0);
        chk("dc_ack_rv", dm_ack, 0);
        tick(); mem_rvalid = 0; dm_req = 1; dm_we = 0; dm_addr = 32'h2C0; #1;
        chk("dc_mreq_idle", mem_req, 0);
        tick(); mem_gnt = 1; #1;
        chk("dc_back_idle", mem_req, 1);
        chk("dc_addr", mem_addr, 32'h2C0);
        tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00000099; #1;
        chk("dc_ack", dm_ack, 1);
        chk("dc_dm_rdata", dm_rdata, 32'h00000099);
        tick(); dm_req = 0; mem_rvalid = 0;

        // Starvation guard: four data grants, then fetch is forced through
        tick(); if_req = 1; if_addr = 32'h500; dm_req = 1; dm_we = 0; dm_addr = 32'h400;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("sv_idle", mem_req, 0);
            tick(); mem_gnt = 1; #1;
            chk("sv_winner", mem_addr, (k == 4) ? 32'h500 : 32'h400);
            tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = k; #1;
            chk("sv_ifv", if_valid, (k == 4) ? 1 : 0);
            chk("sv_ack", dm_ack, (k == 4) ? 0 : 1);
            tick(); mem_rvalid = 0;
        end
        if_req = 0; dm_req = 0;

        // Reset in WAIT_D, then a late response
        tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h600;
        tick(); mem_gnt = 1;
        tick(); mem_gnt = 0; #1;
        chk("rw_hold_addr", mem_addr, 32'h600);
        rst_n = 0; #1;
        chk("rw_mreq", mem_req, 0);
        chk("rw_addr", mem_addr, 0);
        chk("rw_ack", dm_ack, 0);
        chk("rw_dm_stall", dm_stall, 1);
        dm_req = 0;
        tick(); rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h00000BAD; #1;
        chk("rw_late_ack", dm_ack, 0);
        chk("rw_late_ifv", if_valid, 0);
        chk("rw_late_rdata", dm_rdata, 0);
        tick(); mem_rvalid = 0; #1;
        chk("rw_idle", mem_req, 0);
        tick();

        // Randomized traffic against a transaction-level model
        streak = 0; t_active = 0; t_granted = 0; t_killed = 0; t_lat = 0;
        f_req = 0; d_req = 0; d_we = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
        arb_prev = 0; p_if = 0; p_dm = 0; p_dwe = 0; p_faddr = 0; p_daddr = 0; p_dwdata = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!t_active) begin
                chk("rnd_issue", mem_req, arb_prev);
                if (mem_req && arb_prev) begin
                    exp_fetch = p_if && (!p_dm || streak == C_STARVE_LIMIT);
                    t_active  = 1; t_granted = 0; t_killed = 0; t_fetch = exp_fetch;
                    t_addr    = exp_fetch ? p_faddr : p_daddr;
                    t_we      = exp_fetch ? 1'b0 : p_dwe;
                    t_wdata   = p_dwdata;
                    if (exp_fetch || !p_if) streak = 0;
                    else if (streak < C_STARVE_LIMIT) streak++;
                end
            end
            idle_now = !t_active;

            if_req = f_req; if_addr = f_addr;
            dm_req = d_req; dm_we = d_we; dm_addr = d_addr; dm_wdata = d_wdata;
            gnt_b   = t_active && !t_granted && ($urandom % 2 == 0);
            rv_real = t_granted && (t_lat == 0);
            rd      = $urandom;
            if (rv_real && !t_we) rd = memv.exists(t_addr) ? memv[t_addr] : ~t_addr;
            rv_b    = rv_real || (!t_granted && ($urandom % 8 == 0));
            disc_b  = t_active && t_fetch && !t_killed && ($urandom % 6 == 0);
            mem_gnt = gnt_b; mem_rvalid = rv_b; mem_rdata = rd; if_discard = disc_b;
            #1;

            exp_ifv = rv_real && t_fetch && !t_killed && !disc_b;
            exp_ack = rv_real && !t_fetch;
            chk("rnd_ifv", if_valid, exp_ifv);
            chk("rnd_if_rdata", if_rdata, exp_ifv ? rd : 32'h0);
            chk("rnd_ack", dm_ack, exp_ack);
            chk("rnd_dm_rdata", dm_rdata, (exp_ack && !t_we) ? rd : 32'h0);
            chk("rnd_if_stall", if_stall, f_req && !exp_ifv);
            chk("rnd_dm_stall", dm_stall, d_req && !exp_ack);
            if (t_active && !t_granted) begin
                chk("rnd_hold_req", mem_req, 1);
                chk("rnd_hold_addr", mem_addr, t_addr);
                chk("rnd_hold_we", mem_we, t_we);
                if (!t_fetch) chk("rnd_hold_wdata", mem_wdata, t_wdata);
            end
            if (idle_now) begin
                chk("rnd_idle_addr", mem_addr, 0);
                chk("rnd_idle_wdata", mem_wdata, 0);
            end

            if (t_active && !t_granted) begin
                if (t_fetch && disc_b && !gnt_b) begin
                    t_active = 0;
                end else if (gnt_b) begin
                    t_granted = 1;
                    t_lat     = $urandom % 3;
                    if (disc_b) t_killed = 1;
                end
            end else if (t_granted) begin
                if (rv_real) begin
                    if (t_we) memv[t_addr] = t_wdata;
                    if (!t_fetch) d_req = 0;
                    else if (exp_ifv) f_req = 0;
                    t_active = 0; t_granted = 0;
                end else begin
                    t_lat--;
                    if (disc_b) t_killed = 1;
                end
            end
            if (disc_b) f_addr = 32'h1000 + 4 * ($urandom % 64);

            p_if = if_req; p_dm = dm_req; p_faddr = if_addr;
            p_daddr = dm_addr; p_dwe = dm_we; p_dwdata = dm_wdata;
            arb_prev = idle_now && (if_req || dm_req);
            if (!f_req && ($urandom % 2 == 0)) begin
                f_req  = 1;
                f_addr = 32'h1000 + 4 * ($urandom % 64);
            end
            if (!d_req && ($urandom % 4 != 0)) begin
                d_req   = 1;
                d_we    = $urandom % 2;
                d_addr  = 32'h8000 + 4 * ($urandom % 8);
                d_wdata = $urandom;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
